serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 33 +++
 rtl/half.sv | 14 +
 rtl/serial_adder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Full adder built from two half adders plus an OR of their carries.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic s0;
  logic c0;
  logic c1;

  half u_h0 (
    .A    (A),
    .B    (B),
    .Sum  (s0),
    .Cout (c0)
  );

  half u_h1 (
    .A    (s0),
    .B    (Cin),
    .Sum  (Sum),
    .Cout (c1)
  );

  // At most one of the two half-adder carries can be set, so OR is the majority.
  assign Cout = c0 | c1;

endmodule

// File: rtl/half.sv
// Half adder cell: single-bit sum and carry of two inputs.
// Latency: combinational.
// Backpressure: none.
module half (
  input  logic A,
  input  logic B,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B;
  assign Cout = A & B;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell adds A+B LSB-first, one bit per clock.
// Latency: done/Sum/Carry registered WIDTH+1 cycles after the accepting start edge.
// Backpressure: start is only sampled in IDLE; requests in SHIFT/DONE are dropped.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;

  logic               fa_s;
  logic               fa_c;

  full_adder u_fa (
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .Cin  (c_q),
    .Sum  (fa_s),
    .Cout (fa_c)
  );

  // Next-state, datapath and output-register logic; everything holds by default.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    carry_d  = carry_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = A;
          b_sr_d  = B;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        // Sum bits enter at the MSB so bit 0 lands at index 0 after WIDTH shifts.
        sum_sr_d = sum_sr_q >> 1;
        sum_sr_d[WIDTH-1] = fa_s;
        c_d      = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Results are published only here, so partial sums never reach Sum.
        sum_d   = sum_sr_q;
        carry_d = c_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Sum   = sum_q;
  assign Carry = carry_q;

endmodule
